// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg: constants and FSM state type shared by uart_tx / uart_rx   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package uart_pkg;

  localparam int UART_CPB        = 434;
  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_sync_fifo: single-clock FIFO with first-word-fall-through head  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam logic [c_PTR_W:0] c_FULL = (c_PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic               w_wr;
  logic               w_rd;

  assign full  = (r_count == c_FULL);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // Guard internally too, so a misbehaving caller cannot corrupt the count.
  assign w_wr = push && !full;
  assign w_rd = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : uart_sync_fifo
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_fifo: 8N1 UART transmitter fed by a byte FIFO                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CPB   = UART_CPB,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   tx,
  output logic                   tx_busy,
  output logic                   tx_done,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int c_CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int c_IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CPB - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_DONE = c_CNT_W'(CPB - 2);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(UART_DATA_BITS - 1);

  uart_state_e        r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_IDX_W-1:0] r_idx;
  logic [7:0]         r_shift;
  logic               r_tx;
  logic               r_busy;
  logic               r_done;

  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_bit_end;
  logic [7:0]         w_head;

  assign tx_ready  = !w_full;
  assign w_push    = tx_valid && !w_full;
  assign w_bit_end = (r_cnt == c_CNT_LAST);
  // Popping at the last stop clock lets the next start bit follow with no gap.
  assign w_pop     = !w_empty &&
                     ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));

  assign tx      = r_tx;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (tx_data),
    .dout  (w_head),
    .count (fifo_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // Registered one clock early so the pulse covers the final stop clock.
      r_done <= (r_state == ST_STOP) && (r_cnt == c_CNT_DONE);
      r_cnt  <= w_bit_end ? '0 : r_cnt + 1'b1;

      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          r_tx  <= 1'b1;
          if (w_pop) begin
            r_shift <= w_head;
            r_state <= ST_START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end

        ST_START: begin
          if (w_bit_end) begin
            r_state <= ST_DATA;
            r_idx   <= '0;
            r_tx    <= r_shift[0];
          end
        end

        ST_DATA: begin
          if (w_bit_end) begin
            if (r_idx == c_IDX_LAST) begin
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
              r_idx   <= r_idx + 1'b1;
            end
          end
        end

        ST_STOP: begin
          if (w_bit_end) begin
            if (w_pop) begin
              r_shift <= w_head;
              r_state <= ST_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule : uart_tx_fifo
`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

UART transmitter with an input byte FIFO; the upstream stage of `uart_rx`. It accepts bytes over a valid/ready handshake, buffers them, and serializes each as an 8N1 frame on `tx`: start bit, 8 data bits LSB first, one stop bit, each bit lasting `CPB` clocks. Its `tx` drives the serial line that `uart_rx` samples, so both blocks must use the same `CPB`.

## Interface
- `CPB`, 434: clocks per bit; must be ≥ 2.
- `DEPTH`, 8: FIFO entries; must be a power of two, ≥ 2.
- `clk` input 1: single clock; everything is updated on the rising edge.
- `rst` input 1: asynchronous, active-low reset; asserts immediately, deasserts synchronously to `clk`.
- `tx_data` input 8: byte to send.
- `tx_valid` input 1: `tx_data` is valid.
- `tx_ready` output 1: FIFO can accept a byte; equals `fifo_count < DEPTH`, computed from registered state.
- `tx` output 1: serial line, registered, idles high.
- `tx_busy` output 1: a frame is in progress (state ≠ IDLE).
- `tx_done` output 1: one-cycle pulse on the last clock of each stop bit.
- `fifo_count` output $clog2(DEPTH)+1: bytes currently buffered, excluding the frame in progress.

## Operation
- Push: a byte is written on every edge where `tx_valid && tx_ready`.
  - `tx_valid` while `tx_ready`=0 is ignored; no byte is written and no error is flagged.
- FSM states: IDLE, START, DATA, STOP.
- A bit counter runs 0..CPB-1 and a bit index runs 0..7.
- IDLE:
  - `tx`=1.
  - If `fifo_count`>0, pop the head into the shift register, clear the counter, and go to START.
- START:
  - `tx`=0 for CPB clocks, then go to DATA with index 0.
- DATA:
  - `tx`=shift[0] for CPB clocks per bit; the register shifts right at each bit end.
  - After index 7 completes, go to STOP.
- STOP:
  - `tx`=1 for CPB clocks.
  - On the last clock, pulse `tx_done`.
  - If the FIFO is non-empty, pop and go directly to START, giving zero gap between frames; otherwise go to IDLE.
- A frame is exactly 10·CPB clocks.
- Simultaneous push and pop: both take effect and `fifo_count` is unchanged.
  - Case FIFO full: no push happens that edge, because `tx_ready` was 0.
  - Case FIFO empty: a push and an IDLE pop cannot coincide; the popped byte must already be stored.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. The count is tracked separately.
- `tx_data` is sampled only at the push edge. The data in a frame never changes after its pop.
- Reset, including mid-frame:
  - `tx`=1, `tx_busy`=0, `tx_done`=0, `fifo_count`=0, `tx_ready`=1.
  - FSM goes to IDLE, pointers and counters are cleared, and FIFO contents are discarded.
  - A truncated frame is left on the line; `uart_rx` must resync on the next start edge.

## Timing
- Latency: byte accepted at edge E with FSM IDLE and FIFO empty.
  - `fifo_count`=1 after E.
  - Pop at E+1: `tx` falls and `tx_busy` rises after E+1; `fifo_count` returns to 0.
- Data bit i is driven from E+1+(1+i)·CPB for CPB clocks.
- The stop bit starts at E+1+9·CPB.
- `tx_done` is high during the clock ending at E+1+10·CPB.
- The next start bit, if any is queued, begins at that same edge.
- `tx_ready` goes low the clock after the DEPTH-th outstanding push. It returns high the clock after the next pop.

## Structure
- Shared package `uart_pkg`:
  - default `CPB`
  - `UART_DATA_BITS`=8 and `UART_FRAME_BITS`=10
  - the state enum, also reused by `uart_rx`
- Sub-module `uart_sync_fifo`, parameterised width/depth:
  - ports: push/pop/din/dout/count/full/empty
  - same `clk`/`rst` convention
- The top level holds the FSM, bit counter, bit index and shift register.

## Test plan
- Single byte 8'h5E with CPB=4:
  - `tx` reads 0,0,1,1,1,1,0,1,0,1 (start, LSB-first data, stop), each value held 4 clocks.
  - `tx_done` pulses once, 41 clocks after the accepting edge.
- Loopback `tx`→`uart_rx.rx` (shared CPB), bytes 8'h00, 8'hFF, 8'hA5:
  - `rx_data` matches each byte in order, with one `rx_done` per byte.
- Burst of 10 pushes with DEPTH=8, `tx_valid` held high:
  - `tx_ready` drops once `fifo_count` hits 8; the burst stalls and then completes.
  - All 10 bytes are transmitted back-to-back with no idle clocks between stop and start.
- Simultaneous push/pop:
  - Push exactly on the STOP-to-START pop edge with `fifo_count`=3; `fifo_count` stays 3.
  - Order is preserved across pointer wrap, checked with 20 sequential bytes.
- Reset asserted mid-DATA of 8'hC3 with 2 bytes queued:
  - `tx`=1 immediately, `fifo_count`=0, `tx_busy`=0, and no `tx_done`.
  - After release, a new byte 8'h3C is sent correctly.
- `tx_valid` pulsed while `tx_ready`=0:
  - The byte is not stored, `fifo_count` is unchanged, and it never appears on `tx`.
